// File: rtl/mss_core2_model_if.sv
// AHB-lite single-master bus between the MSS stand-in and the fabric slave.
interface mss_core2_model_if;
  logic [31:0] MSSHADDR;
  logic [1:0]  MSSHTRANS;
  logic        MSSHWRITE;
  logic [1:0]  MSSHSIZE;
  logic        MSSHLOCK;
  logic [31:0] MSSHWDATA;
  logic [31:0] MSSHRDATA;
  logic        MSSHREADY;
  logic        MSSHRESP;

  modport master (
    output MSSHADDR, MSSHTRANS, MSSHWRITE, MSSHSIZE, MSSHLOCK, MSSHWDATA,
    input  MSSHRDATA, MSSHREADY, MSSHRESP
  );

  modport slave (
    input  MSSHADDR, MSSHTRANS, MSSHWRITE, MSSHSIZE, MSSHLOCK, MSSHWDATA,
    output MSSHRDATA, MSSHREADY, MSSHRESP
  );
endinterface

// File: rtl/mss_core2_model.sv
// MSS_CORE2 stand-in: UART byte -> AHB write + read-back -> UART reply.
// state | meaning
// IDLE  | waiting for a received byte
// WA    | write address phase (NONSEQ, write)
// WD    | write data phase, waiting for MSSHREADY
// RA    | read address phase (NONSEQ, read)
// RD    | read data phase, waiting for MSSHREADY
// TX    | shifting reply byte out on UART_0_TXD
module mss_core2_model #(
  parameter int          BAUD_DIV  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h4005_0000,
  parameter int          AHB_TMO   = 255,
  parameter logic [7:0]  ERR_BYTE  = 8'hEE,
  parameter int          MDC_DIV   = 8,
  parameter int          RST_EXT   = 8
) (
  input  logic               MAC_CLK,
  input  logic               MSS_RESET,
  input  logic               MAINXIN,
  output logic               FAB_CLK,
  output logic               M2F_RESET_N,
  mss_core2_model_if.master  ahb,
  input  logic               F2M_GPI_2,
  input  logic               F2M_GPI_1,
  input  logic               F2M_GPI_0,
  input  logic               UART_0_RXD,
  output logic               UART_0_TXD,
  input  logic [1:0]         MAC_RXD,
  input  logic               MAC_CRSDV,
  input  logic               MAC_RXER,
  output logic [1:0]         MAC_TXD,
  output logic               MAC_TXEN,
  output logic               MAC_MDC,
  inout  wire                MAC_MDIO
);

  typedef enum logic [2:0] {S_IDLE, S_WA, S_WD, S_RA, S_RD, S_TX} state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_t;

  state_t      r_state, w_next;
  rx_t         r_rx_st;
  logic        r_rx_s1, r_rx_s2, r_rx_s3, r_rx_vld;
  logic [15:0] r_rx_cnt, r_tx_cnt, r_tmo;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sr, r_rst_cnt, r_mdc_cnt;
  logic [9:0]  r_tx_sr;
  logic [3:0]  r_tx_bits;
  logic        r_txd, r_m2f_n, r_mdc;
  logic [31:0] r_addr, r_wdata;
  logic [7:0]  w_tx_byte;
  logic        w_unused;

  assign w_unused    = ^{MAINXIN, MAC_RXD, MAC_CRSDV, MAC_RXER, ahb.MSSHRDATA[31:8]};
  assign FAB_CLK     = MAC_CLK;
  assign MAC_TXD     = 2'b00;
  assign MAC_TXEN    = 1'b0;
  assign MAC_MDIO    = 1'bz;
  assign MAC_MDC     = r_mdc;
  assign M2F_RESET_N = r_m2f_n;
  assign UART_0_TXD  = r_txd;
  assign ahb.MSSHSIZE  = 2'b10;
  assign ahb.MSSHLOCK  = 1'b0;
  assign ahb.MSSHADDR  = r_addr;
  assign ahb.MSSHWDATA = r_wdata;

  always_ff @(posedge MAC_CLK) begin
    if (MSS_RESET) begin
      r_rst_cnt <= 8'(RST_EXT);
      r_m2f_n   <= 1'b0;
      r_mdc_cnt <= 8'(MDC_DIV - 1);
      r_mdc     <= 1'b0;
    end else begin
      r_m2f_n   <= (r_rst_cnt <= 8'd1);
      r_rst_cnt <= (r_rst_cnt != 8'd0) ? r_rst_cnt - 8'd1 : 8'd0;
      if (r_mdc_cnt == 8'd0) begin
        r_mdc     <= ~r_mdc;
        r_mdc_cnt <= 8'(MDC_DIV - 1);
      end else begin
        r_mdc_cnt <= r_mdc_cnt - 8'd1;
      end
    end
  end

  // A framing error parks the receiver until the line returns high.
  always_ff @(posedge MAC_CLK) begin
    if (MSS_RESET) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
      r_rx_st  <= RX_IDLE;
      r_rx_cnt <= 16'd0;
      r_rx_bit <= 3'd0;
      r_rx_sr  <= 8'd0;
      r_rx_vld <= 1'b0;
    end else begin
      r_rx_s1  <= UART_0_RXD;
      r_rx_s2  <= r_rx_s1;
      r_rx_s3  <= r_rx_s2;
      r_rx_vld <= 1'b0;
      case (r_rx_st)
        RX_IDLE: if (!r_rx_s2 && r_rx_s3) begin
          r_rx_st  <= RX_START;
          r_rx_cnt <= 16'(BAUD_DIV / 2 - 1);
        end
        RX_START:
          if (r_rx_cnt != 16'd0) r_rx_cnt <= r_rx_cnt - 16'd1;
          else if (!r_rx_s2) begin
            r_rx_st  <= RX_DATA;
            r_rx_cnt <= 16'(BAUD_DIV - 1);
            r_rx_bit <= 3'd0;
          end else r_rx_st <= RX_IDLE;
        RX_DATA:
          if (r_rx_cnt != 16'd0) r_rx_cnt <= r_rx_cnt - 16'd1;
          else begin
            r_rx_sr  <= {r_rx_s2, r_rx_sr[7:1]};
            r_rx_cnt <= 16'(BAUD_DIV - 1);
            r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
          end
        RX_STOP:
          if (r_rx_cnt != 16'd0) r_rx_cnt <= r_rx_cnt - 16'd1;
          else if (r_rx_s2) begin
            r_rx_vld <= 1'b1;
            r_rx_st  <= RX_IDLE;
          end else r_rx_st <= RX_WAIT;
        RX_WAIT: if (r_rx_s2) r_rx_st <= RX_IDLE;
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge MAC_CLK) begin
    if (MSS_RESET) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (r_rx_vld) w_next = S_WA;
      S_WA:   w_next = S_WD;
      S_WD:
        if (ahb.MSSHREADY)     w_next = ahb.MSSHRESP ? S_TX : S_RA;
        else if (r_tmo == 16'd0) w_next = S_TX;
      S_RA:   w_next = S_RD;
      S_RD:   if (ahb.MSSHREADY || r_tmo == 16'd0) w_next = S_TX;
      S_TX:   if (r_tx_cnt == 16'd0 && r_tx_bits == 4'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ahb.MSSHTRANS = 2'b00;
    ahb.MSSHWRITE = 1'b0;
    case (r_state)
      S_WA:    begin ahb.MSSHTRANS = 2'b10; ahb.MSSHWRITE = 1'b1; end
      S_WD:    ahb.MSSHWRITE = 1'b1;
      S_RA:    ahb.MSSHTRANS = 2'b10;
      default: ;
    endcase
  end

  // Only a clean read completion reaches TX with real data; every other entry is an error.
  assign w_tx_byte = (r_state == S_RD && ahb.MSSHREADY && !ahb.MSSHRESP) ?
                     ahb.MSSHRDATA[7:0] : ERR_BYTE;

  always_ff @(posedge MAC_CLK) begin
    if (MSS_RESET) begin
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_tmo     <= 16'd0;
      r_tx_sr   <= 10'h3FF;
      r_tx_cnt  <= 16'd0;
      r_tx_bits <= 4'd0;
      r_txd     <= 1'b1;
    end else begin
      if (r_state == S_IDLE && r_rx_vld) begin
        r_addr  <= BASE_ADDR | {27'd0, F2M_GPI_2, F2M_GPI_1, F2M_GPI_0, 2'b00};
        r_wdata <= {24'd0, r_rx_sr};
      end
      if (r_state == S_WA || r_state == S_RA)
        r_tmo <= 16'(AHB_TMO - 1);
      else if ((r_state == S_WD || r_state == S_RD) && r_tmo != 16'd0)
        r_tmo <= r_tmo - 16'd1;
      if (r_state != S_TX && w_next == S_TX) begin
        r_tx_sr   <= {1'b1, w_tx_byte, 1'b0};
        r_tx_cnt  <= 16'd0;
        r_tx_bits <= 4'd10;
      end else if (r_state == S_TX) begin
        if (r_tx_cnt != 16'd0) r_tx_cnt <= r_tx_cnt - 16'd1;
        else if (r_tx_bits != 4'd0) begin
          r_txd     <= r_tx_sr[0];
          r_tx_sr   <= {1'b1, r_tx_sr[9:1]};
          r_tx_bits <= r_tx_bits - 4'd1;
          r_tx_cnt  <= 16'(BAUD_DIV - 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mss_core2_model.sv
// Bench for mss_core2_model: UART-driven AHB write/read-back with a reactive slave.
module tb_mss_core2_model;
  localparam int          BAUD_DIV  = 16;
  localparam logic [31:0] BASE_ADDR = 32'h4005_0000;
  localparam int          AHB_TMO   = 255;
  localparam int          MDC_DIV   = 8;
  localparam int          RST_EXT   = 8;

  logic clk, rst, mainxin, fab_clk, m2f_n, gpi2, gpi1, gpi0, rxd, txd;
  logic crsdv, rxer, txen, mdc;
  logic [1:0] mac_rxd, mac_txd;
  wire  mac_mdio_unused;

  mss_core2_model_if bus ();

  mss_core2_model dut (
    .MAC_CLK(clk), .MSS_RESET(rst), .MAINXIN(mainxin), .FAB_CLK(fab_clk),
    .M2F_RESET_N(m2f_n), .ahb(bus), .F2M_GPI_2(gpi2), .F2M_GPI_1(gpi1),
    .F2M_GPI_0(gpi0), .UART_0_RXD(rxd), .UART_0_TXD(txd), .MAC_RXD(mac_rxd),
    .MAC_CRSDV(crsdv), .MAC_RXER(rxer), .MAC_TXD(mac_txd), .MAC_TXEN(txen),
    .MAC_MDC(mdc), .MAC_MDIO(mac_mdio_unused)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          cfg_wait = 0;
  bit          cfg_err_wr = 0, cfg_err_rd = 0, cfg_tie0 = 0;
  logic [31:0] cfg_rdata = 32'h0;

  logic [32:0] q_xfer[$];
  logic [31:0] q_wdata[$], q_ad_samp[$], q_wd_samp[$];
  bit          tx_low_seen = 0;
  time         t_addr = 0, t_txlow = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reactive AHB slave and bus monitor, updated every falling edge.
  initial begin : slave
    bit in_data, cur_write;
    int wcnt;
    in_data = 0; cur_write = 0; wcnt = 0;
    bus.MSSHREADY = 1'b1; bus.MSSHRESP = 1'b0; bus.MSSHRDATA = 32'h0;
    forever begin
      @(negedge clk);
      bus.MSSHRDATA = cfg_rdata;
      if (rst) begin
        in_data = 0;
        bus.MSSHREADY = 1'b1;
        bus.MSSHRESP  = 1'b0;
      end else begin
        if (txd === 1'b0) tx_low_seen = 1;
        if (in_data) begin
          q_ad_samp.push_back(bus.MSSHADDR);
          if (cur_write) q_wd_samp.push_back(bus.MSSHWDATA);
          if (cfg_tie0) bus.MSSHREADY = 1'b0;
          else if (wcnt > 0) begin
            bus.MSSHREADY = 1'b0;
            wcnt--;
          end else begin
            bus.MSSHREADY = 1'b1;
            bus.MSSHRESP  = cur_write ? cfg_err_wr : cfg_err_rd;
            if (cur_write) q_wdata.push_back(bus.MSSHWDATA);
            in_data = 0;
          end
        end else begin
          bus.MSSHREADY = !cfg_tie0;
          bus.MSSHRESP  = 1'b0;
        end
        if (bus.MSSHTRANS == 2'b10) begin
          q_xfer.push_back({bus.MSSHWRITE, bus.MSSHADDR});
          t_addr    = $time;
          in_data   = 1;
          wcnt      = cfg_wait;
          cur_write = bus.MSSHWRITE;
        end
      end
    end
  end

  function automatic void model(input logic [7:0] b, input logic [2:0] g,
                                input logic [31:0] rd, input bit ew, input bit er,
                                input bit tie0, output logic [7:0] tx,
                                output int nx, output logic [31:0] addr);
    addr = BASE_ADDR + 32'(g) * 4;
    nx   = (ew || tie0) ? 1 : 2;
    tx   = (ew || er || tie0) ? 8'hEE : rd[7:0];
  endfunction

  task automatic clear_logs();
    q_xfer.delete(); q_wdata.delete(); q_ad_samp.delete(); q_wd_samp.delete();
    tx_low_seen = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (RST_EXT + 2) @(negedge clk);
    clear_logs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok);
    int t;
    b = 8'h00; ok = 0; t = 0;
    while (txd !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (txd === 1'b0) begin
      t_txlow = $time;
      ok = 1;
      repeat (BAUD_DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD_DIV) @(negedge clk);
        b[i] = txd;
      end
      repeat (BAUD_DIV) @(negedge clk);
      if (txd !== 1'b1) ok = 0;
    end
  endtask

  task automatic run_txn(input string name, input logic [7:0] b, input logic [2:0] g,
                         input logic [31:0] rd, input int ws, input bit ew, input bit er);
    logic [7:0] got, exp_tx;
    logic [31:0] exp_a;
    int exp_n;
    bit ok, bad;
    cfg_wait = ws; cfg_err_wr = ew; cfg_err_rd = er; cfg_rdata = rd; cfg_tie0 = 0;
    {gpi2, gpi1, gpi0} = g;
    clear_logs();
    model(b, g, rd, ew, er, 1'b0, exp_tx, exp_n, exp_a);
    fork
      send_byte(b);
      recv_byte(got, ok);
    join
    repeat (BAUD_DIV + 4) @(negedge clk);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL %s uart_frame: no valid reply frame", name); end
    n_checks++;
    if (got !== exp_tx) begin
      n_errors++; $display("FAIL %s tx_byte got %02h exp %02h", name, got, exp_tx);
    end
    n_checks++;
    if (q_xfer.size() != exp_n) begin
      n_errors++; $display("FAIL %s xfer_count got %0d exp %0d", name, q_xfer.size(), exp_n);
    end
    if (q_xfer.size() >= 1) begin
      n_checks++;
      if (q_xfer[0] !== {1'b1, exp_a}) begin
        n_errors++; $display("FAIL %s write_addr got %09h exp %09h", name, q_xfer[0], {1'b1, exp_a});
      end
    end
    if (exp_n == 2 && q_xfer.size() >= 2) begin
      n_checks++;
      if (q_xfer[1] !== {1'b0, exp_a}) begin
        n_errors++; $display("FAIL %s read_addr got %09h exp %09h", name, q_xfer[1], {1'b0, exp_a});
      end
    end
    n_checks++;
    if (q_wdata.size() != 1 || q_wdata[0] !== {24'h0, b}) begin
      n_errors++;
      $display("FAIL %s wdata got %08h (n=%0d) exp %08h", name,
               (q_wdata.size() > 0) ? q_wdata[0] : 32'hx, q_wdata.size(), {24'h0, b});
    end
    bad = (q_ad_samp.size() != (ws + 1) * exp_n);
    foreach (q_ad_samp[i]) if (q_ad_samp[i] !== exp_a) bad = 1;
    foreach (q_wd_samp[i]) if (q_wd_samp[i] !== {24'h0, b}) bad = 1;
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL %s data_phase_hold got %0d samples exp %0d (addr/wdata held)",
               name, q_ad_samp.size(), (ws + 1) * exp_n);
    end
  endtask

  task automatic test_reset();
    rxd = 1'b1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({txd, bus.MSSHTRANS, bus.MSSHWRITE, m2f_n, mdc, txen, mac_txd} !== 9'b1_00_0_0_0_0_00) begin
      n_errors++;
      $display("FAIL reset_outputs got txd=%b trans=%b write=%b m2f=%b mdc=%b txen=%b txd_mac=%b exp 1 00 0 0 0 0 00",
               txd, bus.MSSHTRANS, bus.MSSHWRITE, m2f_n, mdc, txen, mac_txd);
    end
    n_checks++;
    if (bus.MSSHADDR !== 32'h0 || bus.MSSHWDATA !== 32'h0 || bus.MSSHSIZE !== 2'b10 || bus.MSSHLOCK !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_bus got addr=%08h wdata=%08h size=%b lock=%b exp 0 0 10 0",
               bus.MSSHADDR, bus.MSSHWDATA, bus.MSSHSIZE, bus.MSSHLOCK);
    end
    n_checks++;
    if (fab_clk !== clk) begin n_errors++; $display("FAIL fab_clk got %b exp %b", fab_clk, clk); end
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      n_checks++;
      if (m2f_n !== (n >= RST_EXT)) begin
        n_errors++; $display("FAIL m2f_reset_n cycle %0d got %b exp %b", n, m2f_n, (n >= RST_EXT));
      end
      n_checks++;
      if (mdc !== 1'((n / MDC_DIV) % 2)) begin
        n_errors++; $display("FAIL mac_mdc cycle %0d got %b exp %b", n, mdc, 1'((n / MDC_DIV) % 2));
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_txn("basic", 8'h5A, 3'b101, 32'h0000_00A5, 0, 0, 0);
  endtask

  task automatic test_wait_states();
    run_txn("wait3", 8'h5A, 3'b101, 32'h0000_00A5, 3, 0, 0);
  endtask

  task automatic test_errors();
    run_txn("write_err", 8'hC3, 3'b011, 32'h0000_0011, 1, 1, 0);
    run_txn("read_err", 8'h3C, 3'b110, 32'h0000_0022, 2, 0, 1);
  endtask

  task automatic test_timeout_drop();
    logic [7:0] got;
    bit ok;
    do_reset();
    cfg_tie0 = 1; cfg_wait = 0; cfg_err_wr = 0; cfg_err_rd = 0;
    {gpi2, gpi1, gpi0} = 3'b001;
    fork
      begin send_byte(8'h01); send_byte(8'h77); end
      recv_byte(got, ok);
    join
    n_checks++;
    if (!ok || got !== 8'hEE) begin
      n_errors++; $display("FAIL timeout_byte got %02h ok=%0d exp ee", got, ok);
    end
    n_checks++;
    if ((t_txlow - t_addr) / 10 != AHB_TMO + 2) begin
      n_errors++; $display("FAIL timeout_latency got %0d exp %0d", (t_txlow - t_addr) / 10, AHB_TMO + 2);
    end
    repeat (BAUD_DIV + 4) @(negedge clk);
    tx_low_seen = 0;
    repeat (400) @(negedge clk);
    n_checks++;
    if (q_xfer.size() != 1 || q_xfer[0] !== {1'b1, BASE_ADDR + 32'd4} || tx_low_seen) begin
      n_errors++;
      $display("FAIL busy_drop got xfers=%0d extra_tx=%0d exp 1 write and no further reply",
               q_xfer.size(), tx_low_seen);
    end
    cfg_tie0 = 0;
  endtask

  task automatic test_rx_low();
    rxd = 1'b0;
    do_reset();
    repeat (400) @(negedge clk);
    n_checks++;
    if (q_xfer.size() != 0 || tx_low_seen) begin
      n_errors++; $display("FAIL rx_low_idle got xfers=%0d tx=%0d exp 0 0", q_xfer.size(), tx_low_seen);
    end
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    run_txn("rx_low_then_33", 8'h33, 3'b010, 32'hDEAD_BE5C, 0, 0, 0);
  endtask

  task automatic test_reset_abort();
    int t;
    do_reset();
    cfg_rdata = 32'h0; cfg_wait = 0; cfg_err_wr = 0; cfg_err_rd = 0;
    fork
      send_byte(8'h00);
      begin
        t = 0;
        while (txd !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
      end
    join
    repeat (5) @(negedge clk);
    n_checks++;
    if (txd !== 1'b0) begin n_errors++; $display("FAIL abort_tx_active got txd=%b exp 0", txd); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({txd, bus.MSSHTRANS, m2f_n} !== 4'b1_00_0 || bus.MSSHADDR !== 32'h0 || bus.MSSHWDATA !== 32'h0) begin
      n_errors++;
      $display("FAIL abort_reset got txd=%b trans=%b m2f=%b addr=%08h wdata=%08h exp 1 00 0 0 0",
               txd, bus.MSSHTRANS, m2f_n, bus.MSSHADDR, bus.MSSHWDATA);
    end
    rst = 1'b0;
    repeat (RST_EXT + 2) @(negedge clk);
    clear_logs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic [2:0] g;
    logic [31:0] rd;
    bit ew, er;
    for (int i = 0; i < 12; i++) begin
      b  = 8'($urandom);
      g  = 3'($urandom_range(0, 7));
      rd = $urandom;
      ew = ($urandom_range(0, 7) == 0);
      er = !ew && ($urandom_range(0, 7) == 0);
      run_txn($sformatf("rand%0d", i), b, g, rd, int'($urandom_range(0, 3)), ew, er);
    end
  endtask

  initial begin
    mainxin = 1'b0; mac_rxd = 2'b00; crsdv = 1'b0; rxer = 1'b0;
    gpi2 = 1'b0; gpi1 = 1'b0; gpi0 = 1'b0;
    rxd = 1'b1; rst = 1'b1;
    test_reset();
    test_basic();
    test_wait_states();
    test_errors();
    test_timeout_drop();
    test_rx_low();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
